card_select_ctrl: RTL and testbench
===================================

# card_select_ctrl

Player-input front end for the memory-card game. It debounces the five push-buttons and moves a cursor over the 4x4 card grid. On a select press it reads the card under the cursor from the card RAM and issues a one-cycle `Select` with `CardSelectData`/`CardSelectLoc` to the gameplay state machine, but only if that card is currently hidden. It sits directly upstream of the gameplay controller and shares the card RAM's read port with the display path.

## Interface

Parameters:
- `DB_CYCLES`, default 500000: cycles a raw button must be stable before its debounced level changes (10 ms at 50 MHz).
- `DB_W`, default 20: width of each debounce counter; must satisfy 2^DB_W > DB_CYCLES.

Ports:
- `Clk`  in  1  system clock; single clock domain.
- `Reset`  in  1  synchronous, active-high reset.
- `BtnU`, `BtnD`, `BtnL`, `BtnR`, `BtnC`  in  1 each  raw asynchronous buttons (up/down/left/right/select).
- `Enable`  in  1  high while gameplay is waiting for a card choice; selects are ignored while low.
- `RdLoc`  out  4  card RAM read address; always equals `Cursor`.
- `RdData`  in  6  card RAM read data; synchronous read, valid 1 cycle after `RdLoc`.
- `Cursor`  out  4  current grid index, {row[1:0], col[1:0]}; also consumed by the display.
- `Select`  out  1  one-cycle pulse: card accepted.
- `CardSelectData`  out  6  `RdData` captured for the accepted card; held until the next accept.
- `CardSelectLoc`  out  4  location of the accepted card; held until the next accept.
- `Reject`  out  1  one-cycle pulse: select attempted on a face-up or removed card.

## Operation

Card status encoding is `RdData[5:4]`:
- 01 = hidden. This is the only selectable status.
- 00 = face-up.
- 10 = removed.
- 11 = invalid; treated as not selectable.

Debounce:
- Each button goes through a 2-FF synchronizer, then a counter.
- The counter clears whenever the synchronized level equals the debounced level.
- When the counter reaches `DB_CYCLES - 1`, the debounced level toggles and the counter clears.
- A press event is a one-cycle pulse on a debounced 0->1 transition.

Cursor moves:
- Moves are accepted only in IDLE.
- At most one move is applied per cycle. Priority is U > D > L > R; lower-priority press events in the same cycle are discarded.
- U/D change the row (U decrements); L/R change the column (L decrements).
- Edge behaviour is set by `CARD_SEL_WRAP_EN` (see Configuration).

State machine, one-hot:
- IDLE:
  - BtnC event with `Enable`=1 -> FETCH; the select wins over any move event in the same cycle, which is dropped.
  - BtnC event with `Enable`=0 -> ignored; stay in IDLE.
- FETCH: latch `Cursor` into the pending location; `RdLoc` is already presented -> CHECK.
- CHECK: `RdData` is valid this cycle.
  - Status 01: register `Select`=1, capture data and location -> HOLD.
  - Otherwise: `Reject`=1 -> HOLD.
- HOLD: wait for debounced BtnC = 0, then -> IDLE. Button events seen in HOLD are discarded.
- Illegal state encoding -> IDLE.

## Timing

- Reset values:
  - `Cursor`=0, `RdLoc`=0.
  - `Select`=0, `Reject`=0.
  - `CardSelectData`=0, `CardSelectLoc`=0.
  - State IDLE; all counters and debounced levels 0.
- Reset mid-operation: state returns to IDLE the next edge and no pending `Select`/`Reject` is issued.
- Button held through reset: registers as a new press `DB_CYCLES` cycles after reset deasserts.
- Press latency: press event = raw edge + 2 (sync) + `DB_CYCLES` cycles.
- Move latency: `Cursor` updates on the cycle after the move event.
- Select latency: BtnC event in cycle N -> FETCH in N+1 -> CHECK in N+2 -> `Select`/`Reject` high during N+3, for exactly 1 cycle.
- `CardSelectData`/`CardSelectLoc` become valid in the same cycle `Select` rises.
- Downstream gameplay samples `Select` as a single-cycle strobe; the block never holds it high for 2 or more cycles.
- `Enable` is sampled only at the IDLE select event; dropping it during FETCH/CHECK does not cancel the operation.

## Configuration

- `CARD_SEL_WRAP_EN` defined: the cursor wraps within its row or column. Examples: U at row 0 -> row 3; R at col 3 -> col 0.
- `CARD_SEL_WRAP_EN` undefined: the cursor saturates. Examples: U at row 0 stays at row 0; R at col 3 stays at col 3; no other side effect.

## Test plan

All benches use `DB_CYCLES`=4.
- Reset then idle -> `Cursor`=0, `Select`=0, `Reject`=0, `RdLoc`=0.
- Bounce on BtnR (toggle every 2 cycles for 10 cycles), then hold -> exactly one move; `Cursor` 0->1.
- With `CARD_SEL_WRAP_EN`: press BtnU at `Cursor`=0 -> `Cursor`=12. Without it -> `Cursor`=0.
- `Cursor`=5, `RdData`=6'b01_0111, `Enable`=1, press BtnC -> `Select` high 1 cycle, 3 cycles after the event; `CardSelectData`=6'b010111, `CardSelectLoc`=5.
- `RdData`=6'b10_0011 (removed), press BtnC -> `Reject` 1 cycle, `Select` stays 0, captured outputs unchanged. Repeat with `Enable`=0 -> neither pulse.
- BtnC and BtnL events in the same cycle -> select proceeds and `Cursor` is unchanged. Hold BtnC 50 cycles -> only one `Select`; a second select requires release and re-press.

Source files
------------

// File: rtl/card_select_ctrl.sv
// card_select_ctrl: debounces five buttons, moves a 4x4 grid cursor and qualifies card selects.
// Define CARD_SEL_WRAP_EN for wrapping cursor edges; otherwise the cursor saturates.
module card_select_ctrl #(
    parameter int DB_CYCLES = 500000,
    parameter int DB_W      = 20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       BtnU,
    input  logic       BtnD,
    input  logic       BtnL,
    input  logic       BtnR,
    input  logic       BtnC,
    input  logic       Enable,
    output logic [3:0] RdLoc,
    input  logic [5:0] RdData,
    output logic [3:0] Cursor,
    output logic       Select,
    output logic [5:0] CardSelectData,
    output logic [3:0] CardSelectLoc,
    output logic       Reject
);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        FETCH = 4'b0010,
        CHECK = 4'b0100,
        HOLD  = 4'b1000
    } state_t;
    state_t state_q, state_d;
    logic [4:0] btn_raw, sync1_q, sync2_q, db_q, db_d, tog, ev;
    logic [DB_W-1:0] cnt_q [5];
    logic [DB_W-1:0] cnt_d [5];
    logic [3:0] cursor_q, cursor_d, pend_q, pend_d, loc_q, loc_d;
    logic [5:0] data_q, data_d;
    logic sel_q, sel_d, rej_q, rej_d, hidden;
    logic [1:0] row, col, row_dec, row_inc, col_dec, col_inc;
    assign btn_raw = {BtnC, BtnR, BtnL, BtnD, BtnU};
    assign row = cursor_q[3:2];
    assign col = cursor_q[1:0];
    assign hidden = RdData[5:4] == 2'b01;
`ifdef CARD_SEL_WRAP_EN
    assign row_dec = row - 2'd1;
    assign row_inc = row + 2'd1;
    assign col_dec = col - 2'd1;
    assign col_inc = col + 2'd1;
`else
    assign row_dec = (row == 2'd0) ? row : row - 2'd1;
    assign row_inc = (row == 2'd3) ? row : row + 2'd1;
    assign col_dec = (col == 2'd0) ? col : col - 2'd1;
    assign col_inc = (col == 2'd3) ? col : col + 2'd1;
`endif
    // A press event fires in the cycle the debounced level is about to rise.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            tog[i] = (sync2_q[i] != db_q[i]) && (cnt_q[i] == DB_MAX);
            ev[i] = tog[i] && !db_q[i];
            db_d[i] = db_q[i] ^ tog[i];
            cnt_d[i] = (sync2_q[i] == db_q[i] || tog[i]) ? '0 : cnt_q[i] + 1'b1;
        end
    end
    always_comb begin
        state_d = state_q;
        cursor_d = cursor_q;
        pend_d = pend_q;
        sel_d = 1'b0;
        rej_d = 1'b0;
        data_d = data_q;
        loc_d = loc_q;
        case (state_q)
            IDLE: begin
                if (ev[4] && Enable) state_d = FETCH;
                else cursor_d = ev[0] ? {row_dec, col} : ev[1] ? {row_inc, col} :
                                ev[2] ? {row, col_dec} : ev[3] ? {row, col_inc} : cursor_q;
            end
            FETCH: begin
                pend_d = cursor_q;
                state_d = CHECK;
            end
            CHECK: begin
                sel_d = hidden;
                rej_d = !hidden;
                data_d = hidden ? RdData : data_q;
                loc_d = hidden ? pend_q : loc_q;
                state_d = HOLD;
            end
            HOLD: state_d = db_q[4] ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        sync1_q <= btn_raw;
        sync2_q <= sync1_q;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            db_q <= '0;
            cnt_q <= '{default: '0};
            cursor_q <= '0;
            pend_q <= '0;
            sel_q <= 1'b0;
            rej_q <= 1'b0;
            data_q <= '0;
            loc_q <= '0;
        end else begin
            state_q <= state_d;
            db_q <= db_d;
            cnt_q <= cnt_d;
            cursor_q <= cursor_d;
            pend_q <= pend_d;
            sel_q <= sel_d;
            rej_q <= rej_d;
            data_q <= data_d;
            loc_q <= loc_d;
        end
    end
    assign RdLoc = cursor_q;
    assign Cursor = cursor_q;
    assign Select = sel_q;
    assign Reject = rej_q;
    assign CardSelectData = data_q;
    assign CardSelectLoc = loc_q;
endmodule

// File: tb/tb_card_select_ctrl.sv
// tb_card_select_ctrl: scoreboard bench for card_select_ctrl with DB_CYCLES=4.
module tb_card_select_ctrl;
    localparam int DB = 4;
    typedef struct {logic sel; logic [5:0] data; logic [3:0] loc;} exp_t;
    logic Clk = 1'b0, Reset = 1'b1, Enable = 1'b0, Select, Reject;
    logic [4:0] btn = '0;
    logic [3:0] RdLoc, Cursor, CardSelectLoc;
    logic [5:0] RdData = '0, CardSelectData;
    logic [5:0] mem [16];
    exp_t sb[$];
    int compared = 0, mismatched = 0, n_pulse = 0, n_sel = 0, c_mv = 0;
    logic sel_prev = 1'b0;
    card_select_ctrl #(.DB_CYCLES(DB), .DB_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .BtnU(btn[0]), .BtnD(btn[1]), .BtnL(btn[2]), .BtnR(btn[3]),
        .BtnC(btn[4]), .Enable(Enable), .RdLoc(RdLoc), .RdData(RdData), .Cursor(Cursor),
        .Select(Select), .CardSelectData(CardSelectData), .CardSelectLoc(CardSelectLoc),
        .Reject(Reject)
    );
    always #5 Clk = ~Clk;
    always @(posedge Clk) RdData <= mem[RdLoc];
    always @(negedge Clk) begin
        if (Select || Reject) begin
            exp_t e;
            n_pulse++;
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_pulse: Select=%b Reject=%b but none expected", Select, Reject);
            end else begin
                e = sb.pop_front();
                if ({Select, Reject} !== {e.sel, !e.sel} || CardSelectData !== e.data || CardSelectLoc !== e.loc) begin
                    mismatched++;
                    $display("FAIL pulse_result: got sel=%b rej=%b data=%h loc=%0d, want sel=%b rej=%b data=%h loc=%0d",
                             Select, Reject, CardSelectData, CardSelectLoc, e.sel, !e.sel, e.data, e.loc);
                end
            end
        end
        if (Select) begin
            n_sel++;
            compared++;
            if (sel_prev) begin
                mismatched++;
                $display("FAIL select_width: Select high %0d consecutive cycles, want 1", 2);
            end
        end
        sel_prev = Select;
    end
    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask
    task automatic press(input int i);
        cyc(1);
        btn[i] = 1'b1;
        cyc(12);
        btn[i] = 1'b0;
        cyc(12);
    endtask
    task automatic pulse_reset();
        cyc(1);
        Reset = 1'b1;
        cyc(2);
        Reset = 1'b0;
    endtask
    task automatic test_reset();
        cyc(3);
        Reset = 1'b0;
        cyc(5);
        compared++;
        if ({Cursor, RdLoc, Select, Reject, CardSelectData, CardSelectLoc} !== '0) begin
            mismatched++;
            $display("FAIL reset_state: Cursor=%0d RdLoc=%0d Sel=%b Rej=%b data=%h loc=%0d, want all 0",
                     Cursor, RdLoc, Select, Reject, CardSelectData, CardSelectLoc);
        end
    endtask
    task automatic test_edge();
        logic [3:0] exp_u, exp_l;
`ifdef CARD_SEL_WRAP_EN
        exp_u = 4'd12;
        exp_l = 4'd15;
`else
        exp_u = 4'd0;
        exp_l = 4'd0;
`endif
        press(0);
        compared++;
        if (Cursor !== exp_u) begin
            mismatched++;
            $display("FAIL edge_up: Cursor=%0d want %0d", Cursor, exp_u);
        end
        press(2);
        compared++;
        if (Cursor !== exp_l) begin
            mismatched++;
            $display("FAIL edge_left: Cursor=%0d want %0d", Cursor, exp_l);
        end
        pulse_reset();
        compared++;
        if (Cursor !== 4'd0) begin
            mismatched++;
            $display("FAIL cursor_after_reset: Cursor=%0d want 0", Cursor);
        end
    endtask
    task automatic test_bounce();
        cyc(1);
        for (int i = 0; i < 5; i++) begin
            btn[3] = ~btn[3];
            cyc(2);
        end
        btn[3] = 1'b1;
        cyc(12);
        btn[3] = 1'b0;
        cyc(12);
        compared++;
        if (Cursor !== 4'd1) begin
            mismatched++;
            $display("FAIL bounce_move: Cursor=%0d want 1", Cursor);
        end
    endtask
    task automatic test_move_latency();
        logic [3:0] prev;
        prev = Cursor;
        cyc(1);
        btn[1] = 1'b1;
        for (int c = 1; c <= 20 && c_mv == 0; c++) begin
            @(negedge Clk);
            if (Cursor !== prev) c_mv = c;
        end
        cyc(6);
        btn[1] = 1'b0;
        cyc(12);
        compared++;
        if (Cursor !== 4'd5 || c_mv < 2 + DB || c_mv > 2 + DB + 2) begin
            mismatched++;
            $display("FAIL move_down: Cursor=%0d latency=%0d, want 5 within %0d..%0d", Cursor, c_mv, 2 + DB, 4 + DB);
        end
    endtask
    task automatic test_select();
        int c_sel, s0;
        c_sel = 0;
        s0 = n_sel;
        mem[5] = 6'b01_0111;
        Enable = 1'b1;
        sb.push_back('{1'b1, 6'b010111, 4'd5});
        cyc(1);
        btn[4] = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge Clk);
            if (Select && c_sel == 0) c_sel = c;
        end
        cyc(1);
        btn[4] = 1'b0;
        cyc(15);
        compared++;
        if (c_sel !== c_mv + 2) begin
            mismatched++;
            $display("FAIL select_latency: seen at cycle %0d want %0d", c_sel, c_mv + 2);
        end
        compared++;
        if (n_sel - s0 !== 1 || CardSelectData !== 6'b010111 || CardSelectLoc !== 4'd5) begin
            mismatched++;
            $display("FAIL select_hold: selects=%0d data=%h loc=%0d want 1 17 5", n_sel - s0, CardSelectData, CardSelectLoc);
        end
    endtask
    task automatic test_reject();
        int p0;
        mem[5] = 6'b10_0011;
        sb.push_back('{1'b0, 6'b010111, 4'd5});
        press(4);
        Enable = 1'b0;
        p0 = n_pulse;
        press(4);
        compared++;
        if (n_pulse !== p0) begin
            mismatched++;
            $display("FAIL enable_low: pulses=%0d want 0", n_pulse - p0);
        end
    endtask
    task automatic test_back_to_back();
        int s0;
        mem[5] = 6'b01_1010;
        Enable = 1'b1;
        s0 = n_sel;
        sb.push_back('{1'b1, 6'b011010, 4'd5});
        cyc(1);
        btn[4] = 1'b1;
        btn[2] = 1'b1;
        cyc(12);
        btn[4] = 1'b0;
        btn[2] = 1'b0;
        cyc(12);
        compared++;
        if (Cursor !== 4'd5) begin
            mismatched++;
            $display("FAIL select_beats_move: Cursor=%0d want 5", Cursor);
        end
        sb.push_back('{1'b1, 6'b011010, 4'd5});
        press(4);
        compared++;
        if (n_sel - s0 !== 2) begin
            mismatched++;
            $display("FAIL reselect: selects=%0d want 2", n_sel - s0);
        end
    endtask
    task automatic test_reset_mid();
        int p0;
        p0 = n_pulse;
        cyc(1);
        btn[4] = 1'b1;
        cyc(c_mv - 1);
        Reset = 1'b1;
        btn[4] = 1'b0;
        cyc(3);
        Reset = 1'b0;
        cyc(20);
        compared++;
        if (n_pulse !== p0 || Cursor !== 4'd0) begin
            mismatched++;
            $display("FAIL reset_mid_op: pulses=%0d Cursor=%0d want 0 0", n_pulse - p0, Cursor);
        end
    endtask
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 6'b00_0000;
        test_reset();
        test_edge();
        test_bounce();
        test_move_latency();
        test_select();
        test_reject();
        test_back_to_back();
        test_reset_mid();
        compared++;
        if (sb.size() !== 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d pulses never arrived, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
